i2c_master_seq: RTL
===================

Name: i2c_master_seq

Overview:
Sequencing controller for the I2C master datapath. It generates SCL from the system clock and produces the 4-bit state code that the datapath decodes. It also emits the scl_n strobe on which the datapath updates, and samples slave ACK bits. Each transaction is one request: START, 7-bit address + R/W, ACK, one data byte (write or read), ACK/NACK slot, STOP.

Parameters:
DIV, 250, system clocks per SCL half-period; legal range 2..65535; divider counter is 16 bits.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req  in  1  start transaction; sampled only in IDLE
rw  in  1  0 = write, 1 = read; latched with req
bit_done  in  1  datapath "last bit of byte" flag, valid in ADDRESS/WRITE/READ
sda_in  in  1  sampled SDA line
state  out  4  state code to datapath
scl  out  1  SCL level
scl_n  out  1  one-clk strobe at each SCL falling point; state advances on the same edge
busy  out  1  high from req accept until return to IDLE
done  out  1  one-clk pulse on return to IDLE
ack_err  out  1  sticky: slave NACK seen; cleared on next accepted req

Behaviour:
- Reset is asynchronous, active-low (rst_n), clock clk. Reset state: state=IDLE(0), scl=1, busy=0, done=0, ack_err=0, divider=0, rw_q=0. Reset mid-transaction aborts immediately; no STOP is generated.
- State codes: IDLE=0, START=1, ADDRESS=2, READ_ACK=3 (address ACK), WRITE=4, READ=5, READ_ACK_1=6 (master ACK slot after read, released = NACK), WRITE_ACK=7 (data ACK), STOP=8. Codes 9..15 go to IDLE on the next clk.
- Divider: held at 0 in IDLE; otherwise counts 0..DIV-1 and wraps. tick = (div==DIV-1).
- scl_n = tick & scl & state not in {IDLE, STOP} (combinational). scl_p = tick & ~scl (internal, rising point).
- SCL register: 1 in IDLE. Toggles on every tick in START..WRITE_ACK. In STOP it rises on the first tick, then holds 1.
- IDLE: req=1 at a clk edge -> state=START, busy=1, rw_q=rw, ack_err=0, divider=0, scl stays 1. req while busy is ignored; no queuing.
- START -> ADDRESS on scl_n (first SCL fall, one half-period after accept).
- ADDRESS -> READ_ACK on scl_n when bit_done=1; otherwise remains.
- READ_ACK: ack_q <= sda_in on scl_p. On scl_n: if ack_q=1, go to STOP and set ack_err=1. Else go to WRITE (rw_q=0) or READ (rw_q=1).
- WRITE -> WRITE_ACK, and READ -> READ_ACK_1, on scl_n when bit_done=1.
- WRITE_ACK: sample on scl_p as above. On scl_n -> STOP; set ack_err if NACK.
- READ_ACK_1 -> STOP on scl_n; no sampling.
- STOP: entered with scl=0. First tick raises scl. Second tick -> IDLE with busy=0 and done=1 for exactly one clk.
- Each bit occupies 2 half-periods (low, then high), entered at scl_n.
- Full transaction = 39 half-periods = 39*DIV clk from accept edge to done.
- Address-NACK abort = 21 half-periods.
- bit_done outside ADDRESS/WRITE/READ is ignored.
- sda_in changing while scl=1 outside START/STOP is not checked.

Test Plan:
1. DIV=4, reset then release, no req -> state=0, scl=1, busy=0, no scl_n pulses for 1000 clk.
2. DIV=4, write (rw=0), bench models bit_done per 8 scl_n strobes, sda_in=0 during both ACK slots -> state sequence 1,2,3,4,7,8,0; exactly 19 scl_n pulses; done 156 clk after accept edge; ack_err=0.
3. DIV=4, read (rw=1), address ACK=0 -> sequence 1,2,3,5,6,8,0; done at 156 clk; scl period 8 clk throughout.
4. DIV=4, address slot sda_in=1 -> sequence 1,2,3,8,0; ack_err=1; done at 84 clk. Next req clears ack_err on accept edge.
5. req held high through a transaction plus a second req pulse mid-ADDRESS -> only one transaction runs. A new one starts on the first clk after done if req is still high.
6. rst_n asserted mid-WRITE -> same clk: state=0, scl=1, busy=0, done stays 0. Post-reset req starts a clean START.

Source files
------------

// File: rtl/i2c_master_seq_if.sv
// Bus between the I2C sequencing controller and the datapath it steers.
// The controller takes the master modport; the datapath side takes slave.
interface i2c_master_seq_if;
    logic       req;
    logic       rw;
    logic       bit_done;
    logic       sda_in;
    logic [3:0] state;
    logic       scl;
    logic       scl_n;
    logic       busy;
    logic       done;
    logic       ack_err;

    modport master (
        input  req, rw, bit_done, sda_in,
        output state, scl, scl_n, busy, done, ack_err
    );

    modport slave (
        output req, rw, bit_done, sda_in,
        input  state, scl, scl_n, busy, done, ack_err
    );
endinterface

// File: rtl/i2c_master_seq.sv
// I2C master sequencer: divides clk into SCL, walks one START/addr/data/STOP
// transaction per request and publishes the state code the datapath decodes.
module i2c_master_seq #(
    parameter int unsigned DIV = 250
) (
    input  logic             clk,
    input  logic             rst_n,
    i2c_master_seq_if.master bus
);
    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        START      = 4'd1,
        ADDRESS    = 4'd2,
        READ_ACK   = 4'd3,
        WRITE      = 4'd4,
        READ       = 4'd5,
        READ_ACK_1 = 4'd6,
        WRITE_ACK  = 4'd7,
        STOP       = 4'd8
    } state_t;

    localparam logic [15:0] DIV_LAST = 16'(DIV - 1);

    state_t      state_r, state_nx_s;
    logic [15:0] div_r, div_nx_s;
    logic        scl_r, scl_nx_s;
    logic        rw_r, rw_nx_s;
    logic        ack_r, ack_nx_s;
    logic        busy_r, busy_nx_s;
    logic        done_r, done_nx_s;
    logic        err_r, err_nx_s;
    logic        tick_s, scl_p_s, scl_n_s;

    // Half-period boundary and the SCL rise/fall points derived from it.
    assign tick_s  = (div_r == DIV_LAST);
    assign scl_p_s = tick_s & ~scl_r;
    assign scl_n_s = tick_s & scl_r & (state_r != IDLE) & (state_r != STOP);

    // Next-state, divider, SCL and status logic.
    always_comb begin
        state_nx_s = state_r;
        div_nx_s   = tick_s ? 16'd0 : (div_r + 16'd1);
        scl_nx_s   = scl_r;
        rw_nx_s    = rw_r;
        ack_nx_s   = ack_r;
        busy_nx_s  = busy_r;
        done_nx_s  = 1'b0;
        err_nx_s   = err_r;
        case (state_r)
            IDLE: begin
                div_nx_s = 16'd0;
                scl_nx_s = 1'b1;
                if (bus.req) begin
                    state_nx_s = START;
                    busy_nx_s  = 1'b1;
                    rw_nx_s    = bus.rw;
                    err_nx_s   = 1'b0;
                end else begin
                    busy_nx_s  = 1'b0;
                end
            end
            START: begin
                scl_nx_s = scl_r ^ tick_s;
                if (scl_n_s) begin
                    state_nx_s = ADDRESS;
                end else begin
                    state_nx_s = START;
                end
            end
            ADDRESS: begin
                scl_nx_s = scl_r ^ tick_s;
                if (scl_n_s && bus.bit_done) begin
                    state_nx_s = READ_ACK;
                end else begin
                    state_nx_s = ADDRESS;
                end
            end
            READ_ACK: begin
                scl_nx_s = scl_r ^ tick_s;
                ack_nx_s = scl_p_s ? bus.sda_in : ack_r;
                // The ACK bit was captured on the preceding rise, so ack_r is stable here.
                if (scl_n_s && ack_r) begin
                    state_nx_s = STOP;
                    err_nx_s   = 1'b1;
                end else if (scl_n_s) begin
                    state_nx_s = rw_r ? READ : WRITE;
                end else begin
                    state_nx_s = READ_ACK;
                end
            end
            WRITE, READ: begin
                scl_nx_s = scl_r ^ tick_s;
                if (scl_n_s && bus.bit_done) begin
                    state_nx_s = (state_r == WRITE) ? WRITE_ACK : READ_ACK_1;
                end else begin
                    state_nx_s = state_r;
                end
            end
            WRITE_ACK: begin
                scl_nx_s = scl_r ^ tick_s;
                ack_nx_s = scl_p_s ? bus.sda_in : ack_r;
                if (scl_n_s) begin
                    state_nx_s = STOP;
                    err_nx_s   = err_r | ack_r;
                end else begin
                    state_nx_s = WRITE_ACK;
                end
            end
            READ_ACK_1: begin
                scl_nx_s = scl_r ^ tick_s;
                if (scl_n_s) begin
                    state_nx_s = STOP;
                end else begin
                    state_nx_s = READ_ACK_1;
                end
            end
            STOP: begin
                // Entered with SCL low: first tick releases SCL, second ends the frame.
                if (tick_s && scl_r) begin
                    state_nx_s = IDLE;
                    busy_nx_s  = 1'b0;
                    done_nx_s  = 1'b1;
                end else if (tick_s) begin
                    scl_nx_s   = 1'b1;
                end else begin
                    scl_nx_s   = scl_r;
                end
            end
            default: begin
                state_nx_s = IDLE;
                div_nx_s   = 16'd0;
                scl_nx_s   = 1'b1;
                busy_nx_s  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts without generating STOP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            div_r   <= 16'd0;
            scl_r   <= 1'b1;
            rw_r    <= 1'b0;
            ack_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            div_r   <= div_nx_s;
            scl_r   <= scl_nx_s;
            rw_r    <= rw_nx_s;
            ack_r   <= ack_nx_s;
            busy_r  <= busy_nx_s;
            done_r  <= done_nx_s;
            err_r   <= err_nx_s;
        end
    end

    assign bus.state   = state_r;
    assign bus.scl     = scl_r;
    assign bus.scl_n   = scl_n_s;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.ack_err = err_r;
endmodule
